// File: rtl/neighbor_update_if.sv
// rtl/neighbor_update_if.sv - node memory port shared by the neighbour table readers and writers
interface neighbor_update_if #(
  parameter int WORD_WIDTH = 16
);
  logic [10:0]           address;
  logic [WORD_WIDTH-1:0] data_out;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] data_in;

  modport master (output address, output data_out, output wr_en, input data_in);
  modport slave  (input address, input data_out, input wr_en, output data_in);
endinterface

// File: rtl/neighbor_update.sv
// rtl/neighbor_update.sv - writes a neighbour frame's batteryStat and qValue into the sender's table slot
module neighbor_update #(
  parameter int          WORD_WIDTH    = 16,
  parameter int          MAX_NEIGHBORS = 64,
  parameter logic [10:0] NBR_ID_BASE   = 11'h048,
  parameter logic [10:0] BATT_BASE     = 11'h148,
  parameter logic [10:0] QVAL_BASE     = 11'h1C8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] f_sourceID,
  input  logic [WORD_WIDTH-1:0] f_batteryStat,
  input  logic [WORD_WIDTH-1:0] f_Value,
  input  logic [6:0]            neighbor_count,
  neighbor_update_if.master     bus,
  output logic                  found,
  output logic [5:0]            match_index,
  output logic                  done
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_NEIGHBORS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_SEARCH  = 3'd2,
    S_WR_BATT = 3'd3,
    S_WR_QVAL = 3'd4,
    S_NO_HIT  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                state, state_d;
  logic [5:0]            idx, idx_d;
  logic [6:0]            cnt, cnt_d;
  logic [WORD_WIDTH-1:0] src_q, src_d, batt_q, batt_d, val_q, val_d;
  logic [10:0]           address_q, address_d;
  logic [WORD_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_en_q, wr_en_d;
  logic                  found_d, done_d;
  logic [5:0]            match_index_d;
  logic [6:0]            cnt_clamped;
  logic [5:0]            idx_next;

  function automatic logic [10:0] slot_off(input logic [5:0] i);
    return {4'b0000, i, 1'b0};
  endfunction

  assign cnt_clamped = (neighbor_count > MAX_CNT) ? MAX_CNT : neighbor_count;
  assign idx_next    = idx + 6'd1;

  assign bus.address  = address_q;
  assign bus.data_out = data_out_q;
  assign bus.wr_en    = wr_en_q;

  always_comb begin
    state_d       = state;
    idx_d         = idx;
    cnt_d         = cnt;
    src_d         = src_q;
    batt_d        = batt_q;
    val_d         = val_q;
    address_d     = address_q;
    data_out_d    = data_out_q;
    wr_en_d       = wr_en_q;
    found_d       = found;
    match_index_d = match_index;
    done_d        = done;
    case (state)
      S_IDLE: begin
        if (en) begin
          state_d       = S_ARMED;
          done_d        = 1'b0;
          found_d       = 1'b0;
          match_index_d = '0;
        end
      end
      S_ARMED: begin
        if (start) begin
          src_d  = f_sourceID;
          batt_d = f_batteryStat;
          val_d  = f_Value;
          cnt_d  = cnt_clamped;
          idx_d  = '0;
          // Empty table still takes the spare NO_HIT cycle so both miss paths share timing
          if (cnt_clamped == 7'd0) begin
            found_d = 1'b0;
            state_d = S_NO_HIT;
          end else begin
            address_d = NBR_ID_BASE;
            state_d   = S_SEARCH;
          end
        end
      end
      S_SEARCH: begin
        if (bus.data_in == src_q) begin
          match_index_d = idx;
          address_d     = BATT_BASE + slot_off(idx);
          data_out_d    = batt_q;
          wr_en_d       = 1'b1;
          state_d       = S_WR_BATT;
        end else if ({1'b0, idx} == cnt - 7'd1) begin
          state_d = S_NO_HIT;
        end else begin
          idx_d     = idx_next;
          address_d = NBR_ID_BASE + slot_off(idx_next);
        end
      end
      S_WR_BATT: begin
        address_d  = QVAL_BASE + slot_off(match_index);
        data_out_d = val_q;
        wr_en_d    = 1'b1;
        state_d    = S_WR_QVAL;
      end
      S_WR_QVAL: begin
        wr_en_d = 1'b0;
        found_d = 1'b1;
        state_d = S_DONE;
      end
      S_NO_HIT: begin
        wr_en_d = 1'b0;
        found_d = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      src_q       <= '0;
      batt_q      <= '0;
      val_q       <= '0;
      address_q   <= '0;
      data_out_q  <= '0;
      wr_en_q     <= 1'b0;
      found       <= 1'b0;
      match_index <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      cnt         <= cnt_d;
      src_q       <= src_d;
      batt_q      <= batt_d;
      val_q       <= val_d;
      address_q   <= address_d;
      data_out_q  <= data_out_d;
      wr_en_q     <= wr_en_d;
      found       <= found_d;
      match_index <= match_index_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_neighbor_update.sv
// tb/tb_neighbor_update.sv - directed bench for neighbor_update against a behavioural node memory
module tb_neighbor_update;

  logic        clock;
  logic        rst;
  logic        en;
  logic        start;
  logic [15:0] f_sourceID;
  logic [15:0] f_batteryStat;
  logic [15:0] f_Value;
  logic [6:0]  neighbor_count;
  logic        found;
  logic [5:0]  match_index;
  logic        done;

  neighbor_update_if #(.WORD_WIDTH(16)) bus ();

  neighbor_update dut (
    .clock          (clock),
    .rst            (rst),
    .en             (en),
    .start          (start),
    .f_sourceID     (f_sourceID),
    .f_batteryStat  (f_batteryStat),
    .f_Value        (f_Value),
    .neighbor_count (neighbor_count),
    .bus            (bus),
    .found          (found),
    .match_index    (match_index),
    .done           (done)
  );

  logic [15:0] ram [0:2047];
  logic        pl_en;
  logic [10:0] pl_addr;
  logic [15:0] pl_data;
  logic [10:0] log_addr [$];
  logic [15:0] log_data [$];

  int n_checks = 0;
  int n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.data_in = ram[bus.address];

  always @(posedge clock) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (bus.wr_en) begin
      ram[bus.address] <= bus.data_out;
      log_addr.push_back(bus.address);
      log_data.push_back(bus.data_out);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic poke(input logic [10:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic run_update(input bit arm, input logic [15:0] src, input logic [15:0] batt,
                            input logic [15:0] val, input logic [6:0] cnt, input int max_edges,
                            output int done_edge, output int wr_cycles, output int first_wr,
                            output int addr_moves, output int log_base);
    logic [10:0] prev;
    if (arm) begin
      en = 1'b1;
      tick();
      en = 1'b0;
    end
    log_base       = log_addr.size();
    f_sourceID     = src;
    f_batteryStat  = batt;
    f_Value        = val;
    neighbor_count = cnt;
    start          = 1'b1;
    prev           = bus.address;
    tick();
    start          = 1'b0;
    f_sourceID     = ~src;
    f_batteryStat  = ~batt;
    f_Value        = ~val;
    neighbor_count = 7'd1;
    done_edge  = -1;
    wr_cycles  = 0;
    first_wr   = -1;
    addr_moves = (bus.address != prev) ? 1 : 0;
    prev       = bus.address;
    for (int e = 1; e <= max_edges; e++) begin
      tick();
      if (bus.wr_en) begin
        wr_cycles++;
        if (first_wr < 0) first_wr = e;
      end
      if (bus.address != prev) addr_moves++;
      prev = bus.address;
      if (done) begin
        done_edge = e;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int de, wc, fw, am, lb;
    logic [15:0] tbl5 [5];
    logic [15:0] dup6 [6];
    tbl5 = '{16'd7, 16'd12, 16'd9, 16'd30, 16'd4};
    dup6 = '{16'd20, 16'd21, 16'd22, 16'd23, 16'd21, 16'd25};
    rst = 1'b1; en = 1'b0; start = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    f_sourceID = '0; f_batteryStat = '0; f_Value = '0; neighbor_count = '0;
    repeat (2) tick();
    check("rst_address", 32'(bus.address), 32'h0);
    check("rst_data_out", 32'(bus.data_out), 32'h0);
    check("rst_wr_en", 32'(bus.wr_en), 32'h0);
    check("rst_found", 32'(found), 32'h0);
    check("rst_match_index", 32'(match_index), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    tick();

    // Match at slot 2 of a five-entry table
    for (int i = 0; i < 5; i++) poke(11'h048 + 11'(2 * i), tbl5[i]);
    run_update(1'b1, 16'd9, 16'h00A5, 16'h0133, 7'd5, 20, de, wc, fw, am, lb);
    check("match_done_edge", 32'(de), 32'd6);
    check("match_wr_cycles", 32'(wc), 32'd2);
    check("match_first_wr", 32'(fw), 32'd3);
    check("match_found", 32'(found), 32'h1);
    check("match_index", 32'(match_index), 32'd2);
    check("match_nwrites", 32'(log_addr.size() - lb), 32'd2);
    if (log_addr.size() - lb == 2) begin
      check("match_batt_addr", 32'(log_addr[lb]), 32'h14C);
      check("match_batt_data", 32'(log_data[lb]), 32'h00A5);
      check("match_qval_addr", 32'(log_addr[lb+1]), 32'h1CC);
      check("match_qval_data", 32'(log_data[lb+1]), 32'h0133);
    end
    check("match_ram_batt", 32'(ram[11'h14C]), 32'h00A5);
    check("match_ram_qval", 32'(ram[11'h1CC]), 32'h0133);

    // done holds until the next en, which clears the result flags
    repeat (3) tick();
    check("done_hold", 32'(done), 32'h1);
    check("found_hold", 32'(found), 32'h1);
    en = 1'b1;
    tick();
    en = 1'b0;
    check("arm_clears_done", 32'(done), 32'h0);
    check("arm_clears_found", 32'(found), 32'h0);
    check("arm_clears_index", 32'(match_index), 32'h0);

    // No match on the same table
    run_update(1'b0, 16'd99, 16'h1111, 16'h2222, 7'd5, 20, de, wc, fw, am, lb);
    check("miss_done_edge", 32'(de), 32'd7);
    check("miss_wr_cycles", 32'(wc), 32'd0);
    check("miss_nwrites", 32'(log_addr.size() - lb), 32'd0);
    check("miss_found", 32'(found), 32'h0);
    check("miss_ram_batt", 32'(ram[11'h14C]), 32'h00A5);
    check("miss_ram_qval", 32'(ram[11'h1CC]), 32'h0133);

    // Full table, sender only in the last slot; then the same with an over-range count
    for (int i = 0; i < 63; i++) poke(11'h048 + 11'(2 * i), 16'(1000 + i));
    poke(11'h048 + 11'd126, 16'h5555);
    run_update(1'b1, 16'h5555, 16'hBEEF, 16'hCAFE, 7'd64, 100, de, wc, fw, am, lb);
    check("last_done_edge", 32'(de), 32'd67);
    check("last_match_index", 32'(match_index), 32'd63);
    check("last_nwrites", 32'(log_addr.size() - lb), 32'd2);
    if (log_addr.size() - lb == 2) begin
      check("last_batt_addr", 32'(log_addr[lb]), 32'h1C6);
      check("last_qval_addr", 32'(log_addr[lb+1]), 32'h246);
      check("last_qval_data", 32'(log_data[lb+1]), 32'hCAFE);
    end
    run_update(1'b1, 16'h5555, 16'h1234, 16'h4321, 7'd100, 100, de, wc, fw, am, lb);
    check("clamp_done_edge", 32'(de), 32'd67);
    check("clamp_match_index", 32'(match_index), 32'd63);
    check("clamp_found", 32'(found), 32'h1);
    check("clamp_ram_batt", 32'(ram[11'h1C6]), 32'h1234);
    check("clamp_ram_qval", 32'(ram[11'h246]), 32'h4321);

    // Empty table
    run_update(1'b1, 16'd1000, 16'h7777, 16'h8888, 7'd0, 10, de, wc, fw, am, lb);
    check("empty_done_edge", 32'(de), 32'd2);
    check("empty_found", 32'(found), 32'h0);
    check("empty_addr_moves", 32'(am), 32'd0);
    check("empty_address", 32'(bus.address), 32'h246);
    check("empty_nwrites", 32'(log_addr.size() - lb), 32'd0);

    // Duplicate IDs: the first match wins
    for (int i = 0; i < 6; i++) poke(11'h048 + 11'(2 * i), dup6[i]);
    run_update(1'b1, 16'd21, 16'h0D0D, 16'h0E0E, 7'd6, 20, de, wc, fw, am, lb);
    check("dup_done_edge", 32'(de), 32'd5);
    check("dup_match_index", 32'(match_index), 32'd1);
    if (log_addr.size() - lb == 2) begin
      check("dup_batt_addr", 32'(log_addr[lb]), 32'h14A);
      check("dup_qval_addr", 32'(log_addr[lb+1]), 32'h1CA);
    end else begin
      check("dup_nwrites", 32'(log_addr.size() - lb), 32'd2);
    end

    // start without en does nothing; en+start together only arms
    start = 1'b1;
    f_sourceID = 16'd20;
    neighbor_count = 7'd6;
    repeat (4) tick();
    check("idle_start_address", 32'(bus.address), 32'h1CA);
    check("idle_start_done", 32'(done), 32'h1);
    en = 1'b1;
    tick();
    en = 1'b0;
    start = 1'b0;
    check("en_start_done_clr", 32'(done), 32'h0);
    repeat (3) tick();
    check("en_start_no_search", 32'(bus.address), 32'h1CA);
    run_update(1'b0, 16'd25, 16'h0F0F, 16'h0A0A, 7'd6, 20, de, wc, fw, am, lb);
    check("rearmed_done_edge", 32'(de), 32'd9);
    check("rearmed_match_index", 32'(match_index), 32'd5);

    // Asynchronous reset while searching slot 3
    en = 1'b1;
    tick();
    en = 1'b0;
    f_sourceID = 16'h5555;
    neighbor_count = 7'd64;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("search_slot3_addr", 32'(bus.address), 32'h04E);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_address", 32'(bus.address), 32'h0);
    check("async_rst_data_out", 32'(bus.data_out), 32'h0);
    check("async_rst_done", 32'(done), 32'h0);
    check("async_rst_index", 32'(match_index), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    run_update(1'b1, 16'd22, 16'h0AAA, 16'h0BBB, 7'd6, 20, de, wc, fw, am, lb);
    check("post_rst_done_edge", 32'(de), 32'd6);
    check("post_rst_match_index", 32'(match_index), 32'd2);
    check("post_rst_ram_batt", 32'(ram[11'h14C]), 32'h0AAA);
    check("post_rst_ram_qval", 32'(ram[11'h1CC]), 32'h0BBB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
